// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford pass sequencer: FSM state encoding,
// InputMemory header layout and the outstanding-counter width.
package bf_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_HDR2,
      ST_HDR3,
      ST_INIT,
      ST_ISSUE,
      ST_DRAIN,
      ST_CHECK,
      ST_WB,
      ST_DONE
   } bf_state_t;

   // Header byte addresses in InputMemory
   localparam int unsigned HDR_N    = 0;
   localparam int unsigned HDR_SRC  = 1;
   localparam int unsigned HDR_E_LO = 2;
   localparam int unsigned HDR_E_HI = 3;

   // Width of the in-flight edge counter; holds MAX_OUT up to 15
   localparam int unsigned OUT_W = 4;

   // InputMemory address presented while reading the header; 0 elsewhere
   function automatic logic [1:0] hdr_addr(input bf_state_t st);
      case (st)
         ST_HDR1: hdr_addr = 2'(HDR_SRC);
         ST_HDR2: hdr_addr = 2'(HDR_E_LO);
         ST_HDR3: hdr_addr = 2'(HDR_E_HI);
         default: hdr_addr = 2'(HDR_N);
      endcase
   endfunction

endpackage

// File: rtl/bf_edge_issuer.sv
// Per-pass edge issuer: walks edge indices 0..E-1 over a valid/ready handshake,
// limits edges in flight in the relaxation pipeline, and records whether any
// retired edge lowered a distance during the pass.
module bf_edge_issuer
   import bf_pkg::*;
#(
   parameter int unsigned AW      = 13,
   parameter int unsigned MAX_OUT = 4
)
(
   input  logic          clock,
   input  logic          reset,
   input  logic          restart,
   input  logic          enable,
   input  logic [AW-1:0] edge_count,
   output logic          edge_valid,
   input  logic          edge_ready,
   output logic [AW-1:0] edge_idx,
   input  logic          res_valid,
   input  logic          res_updated,
   output logic          issue_done,
   output logic          pass_complete,
   output logic          pass_upd,
   output logic          stray_result
);

   localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(MAX_OUT);

   logic [AW-1:0]    issued;
   logic [OUT_W-1:0] outstanding;
   logic             handshake;
   logic             retire;

   assign issue_done    = (issued >= edge_count);
   assign edge_valid    = enable && !issue_done && (outstanding < OUT_LIMIT);
   assign edge_idx      = issued;
   assign handshake     = edge_valid && edge_ready;
   assign retire        = res_valid && (outstanding != '0);
   assign stray_result  = res_valid && (outstanding == '0);
   assign pass_complete = issue_done && (outstanding == '0);

   // Issued-edge counter doubles as the next edge index; reset at each pass start
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         issued <= '0;
      end else if (restart) begin
         issued <= '0;
      end else if (handshake) begin
         issued <= issued + 1'b1;
      end
   end

   // Edges in flight: issue and retire in the same cycle cancel out
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outstanding <= '0;
      end else begin
         case ({handshake, retire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Sticky per-pass flag: some counted result reported a distance improvement
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pass_upd <= 1'b0;
      end else if (restart) begin
         pass_upd <= 1'b0;
      end else if (retire && res_updated) begin
         pass_upd <= 1'b1;
      end
   end

endmodule

// File: rtl/bf_pass_scheduler.sv
// Top-level Bellman-Ford sequencer: reads the header, triggers initialisation,
// runs up to N-1 relaxation passes with early exit on convergence, then one
// negative-cycle detection pass, and finally triggers writeback.
module bf_pass_scheduler
   import bf_pkg::*;
#(
   parameter int unsigned AW      = 13,
   parameter int unsigned MAX_OUT = 4
)
(
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] IMAR,
   input  logic [7:0]    IMDR,
   output logic          init_req,
   input  logic          init_done,
   output logic [7:0]    src_node,
   output logic          edge_valid,
   input  logic          edge_ready,
   output logic [AW-1:0] edge_idx,
   output logic          detect_pass,
   input  logic          res_valid,
   input  logic          res_updated,
   output logic          wb_req,
   input  logic          wb_done,
   output logic [7:0]    pass_count,
   output logic          busy,
   output logic          done,
   output logic          NegCycle,
   output logic          protocol_err
);

   bf_state_t     state;
   bf_state_t     state_nx;
   logic [7:0]    n_reg;
   logic [7:0]    e_lo;
   logic [AW-1:0] e_reg;
   logic          accept;
   logic          pass_restart;
   logic          enter_detect;
   logic          issue_en;
   logic          issue_done;
   logic          pass_complete;
   logic          pass_upd;
   logic          stray_result;
   logic [8:0]    pass_count_inc;
   logic [8:0]    n_minus_1;

   assign accept         = (state == ST_IDLE) && start;
   assign pass_count_inc = {1'b0, pass_count} + 9'd1;
   assign n_minus_1      = {1'b0, n_reg} - 9'd1;

   assign IMAR = {{(AW-2){1'b0}}, hdr_addr(state)};
   assign busy = (state != ST_IDLE) && (state != ST_DONE);
   assign done = (state == ST_DONE);

   bf_edge_issuer #(
      .AW      (AW),
      .MAX_OUT (MAX_OUT)
   ) u_issuer (
      .clock         (clock),
      .reset         (reset),
      .restart       (pass_restart),
      .enable        (issue_en),
      .edge_count    (e_reg),
      .edge_valid    (edge_valid),
      .edge_ready    (edge_ready),
      .edge_idx      (edge_idx),
      .res_valid     (res_valid),
      .res_updated   (res_updated),
      .issue_done    (issue_done),
      .pass_complete (pass_complete),
      .pass_upd      (pass_upd),
      .stray_result  (stray_result)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic, pass restart strobe and the relax/detect decision
   always_comb begin
      state_nx     = state;
      pass_restart = 1'b0;
      enter_detect = 1'b0;
      issue_en     = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_HDR0;
         ST_HDR0:  state_nx = ST_HDR1;
         ST_HDR1:  state_nx = ST_HDR2;
         ST_HDR2:  state_nx = ST_HDR3;
         ST_HDR3:  state_nx = ST_INIT;
         ST_INIT: begin
            if (init_done) begin
               if (e_reg == '0) begin
                  state_nx = ST_WB;
               end else begin
                  state_nx     = ST_ISSUE;
                  pass_restart = 1'b1;
                  enter_detect = (n_reg <= 8'd1);
               end
            end
         end
         ST_ISSUE: begin
            issue_en = 1'b1;
            if (issue_done) state_nx = ST_DRAIN;
         end
         ST_DRAIN: if (pass_complete) state_nx = ST_CHECK;
         ST_CHECK: begin
            // pass_count still holds the pre-increment value here
            if (detect_pass || !pass_upd) begin
               state_nx = ST_WB;
            end else begin
               state_nx     = ST_ISSUE;
               pass_restart = 1'b1;
               enter_detect = (pass_count_inc == n_minus_1);
            end
         end
         ST_WB:    if (wb_done) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Header capture: each byte is latched at the end of its read cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         n_reg    <= '0;
         src_node <= '0;
         e_lo     <= '0;
         e_reg    <= '0;
      end else begin
         case (state)
            ST_HDR0: n_reg    <= IMDR;
            ST_HDR1: src_node <= IMDR;
            ST_HDR2: e_lo     <= IMDR;
            ST_HDR3: e_reg    <= AW'({IMDR, e_lo});
            default: ;
         endcase
      end
   end

   // One-cycle request pulses on entry to INIT and WB
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         init_req <= 1'b0;
         wb_req   <= 1'b0;
      end else begin
         init_req <= (state == ST_HDR3);
         wb_req   <= (state_nx == ST_WB) && (state != ST_WB);
      end
   end

   // Relaxation pass counter, cleared when a run is accepted
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pass_count <= '0;
      end else if (accept) begin
         pass_count <= '0;
      end else if ((state == ST_CHECK) && !detect_pass) begin
         pass_count <= pass_count + 8'd1;
      end
   end

   // Detection-pass marker: set when the next pass is the detection pass
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         detect_pass <= 1'b0;
      end else if (accept) begin
         detect_pass <= 1'b0;
      end else if (pass_restart) begin
         detect_pass <= enter_detect;
      end else if (state == ST_CHECK) begin
         detect_pass <= 1'b0;
      end
   end

   // Sticky negative-cycle result from the detection pass
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         NegCycle <= 1'b0;
      end else if (accept) begin
         NegCycle <= 1'b0;
      end else if ((state == ST_CHECK) && detect_pass) begin
         NegCycle <= pass_upd;
      end
   end

   // Sticky protocol error on a result with nothing in flight; a new stray wins over the clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         protocol_err <= 1'b0;
      end else if (stray_result) begin
         protocol_err <= 1'b1;
      end else if (accept) begin
         protocol_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bf_pass_scheduler.sv
// Self-checking bench for bf_pass_scheduler: behavioural InputMemory, init/writeback
// responders and a relaxation pipeline with random ready and latency; expected pass
// counts and results come from a pass-level model of the algorithm's stopping rules.
module tb_bf_pass_scheduler;

   localparam int unsigned AW      = 13;
   localparam int unsigned MAX_OUT = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] IMAR;
   logic [7:0]    IMDR;
   logic          init_req;
   logic          init_done = 1'b0;
   logic [7:0]    src_node;
   logic          edge_valid;
   logic          edge_ready = 1'b0;
   logic [AW-1:0] edge_idx;
   logic          detect_pass;
   logic          res_valid = 1'b0;
   logic          res_updated = 1'b0;
   logic          wb_req;
   logic          wb_done = 1'b0;
   logic [7:0]    pass_count;
   logic          busy;
   logic          done;
   logic          NegCycle;
   logic          protocol_err;

   always #5 clock = ~clock;

   bf_pass_scheduler #(.AW(AW), .MAX_OUT(MAX_OUT)) dut (
      .clock(clock), .reset(reset), .start(start), .IMAR(IMAR), .IMDR(IMDR),
      .init_req(init_req), .init_done(init_done), .src_node(src_node),
      .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_idx(edge_idx),
      .detect_pass(detect_pass), .res_valid(res_valid), .res_updated(res_updated),
      .wb_req(wb_req), .wb_done(wb_done), .pass_count(pass_count), .busy(busy),
      .done(done), .NegCycle(NegCycle), .protocol_err(protocol_err)
   );

   // InputMemory: only the four header bytes are populated
   logic [7:0] hdr [0:3];
   assign IMDR = (IMAR < AW'(4)) ? hdr[IMAR[1:0]] : 8'h00;

   int total = 0;
   int bad   = 0;

   // Per-run environment state
   int cyc, again_cyc, done_cyc, wbdone_cyc;
   int n_init, n_wb, n_done, init_wait, wb_wait;
   int hs_cnt, inflight, max_inflight;
   int cur_n, cur_src, cur_e, cur_upd, lat_min, lat_max;
   bit rdy_all;
   int q_due[$];
   bit q_upd[$];
   int log_idx[$];
   bit log_det[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pass-level algorithm outcome: relaxation pass p improves a distance iff p <= upd
   task automatic model(input int n, input int e, input int upd,
                        output int passes, output int pc, output bit neg, output bit det);
      int r;
      passes = 0; pc = 0; neg = 1'b0; det = 1'b0;
      if (e == 0) return;
      r = (n <= 1) ? 0 : n - 1;
      for (int p = 1; p <= r; p++) begin
         passes = p;
         pc     = p;
         if (p > upd) return;
      end
      det    = 1'b1;
      passes = r + 1;
      neg    = (r + 1 <= upd);
   endtask

   // One clock: observe outputs #1 after the edge, then drive inputs for the next edge
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (init_req) begin n_init++; init_wait = $urandom_range(3, 1); end
      if (wb_req)   begin n_wb++;   wb_wait   = $urandom_range(3, 1); end
      if (done)     begin n_done++; done_cyc  = cyc; end
      start = (cyc == again_cyc);
      init_done = 1'b0;
      if (init_wait > 0) begin
         init_wait--;
         init_done = (init_wait == 0);
      end
      wb_done = 1'b0;
      if (wb_wait > 0) begin
         wb_wait--;
         if (wb_wait == 0) begin wb_done = 1'b1; wbdone_cyc = cyc; end
      end
      edge_ready = rdy_all ? 1'b1 : 1'($urandom_range(1, 0));
      if (edge_valid && edge_ready) begin
         log_idx.push_back(int'(edge_idx));
         log_det.push_back(detect_pass);
         q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
         q_upd.push_back(((cur_e == 0) ? 1 : hs_cnt / cur_e + 1) <= cur_upd);
         hs_cnt++;
         inflight++;
      end
      res_valid   = 1'b0;
      res_updated = 1'b0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
         void'(q_due.pop_front());
         res_updated = q_upd.pop_front();
         res_valid   = 1'b1;
         inflight--;
      end
      if (inflight > max_inflight) max_inflight = inflight;
   endtask

   task automatic check_reset_outputs(input string t);
      chk({t, ":IMAR"}, IMAR, 0);
      chk({t, ":init_req"}, init_req, 0);
      chk({t, ":src_node"}, src_node, 0);
      chk({t, ":edge_valid"}, edge_valid, 0);
      chk({t, ":edge_idx"}, edge_idx, 0);
      chk({t, ":detect_pass"}, detect_pass, 0);
      chk({t, ":wb_req"}, wb_req, 0);
      chk({t, ":pass_count"}, pass_count, 0);
      chk({t, ":busy"}, busy, 0);
      chk({t, ":done"}, done, 0);
      chk({t, ":NegCycle"}, NegCycle, 0);
      chk({t, ":protocol_err"}, protocol_err, 0);
   endtask

   task automatic begin_case(input string t, input int n, input int src, input int e,
                             input logic [7:0] hi_junk, input int upd, input int lmin,
                             input int lmax, input bit rdy1, input int again);
      logic [7:0] e_hi;
      e_hi    = hi_junk | 8'(e >> 8);
      hdr[0]  = 8'(n);
      hdr[1]  = 8'(src);
      hdr[2]  = 8'(e);
      hdr[3]  = e_hi;
      cur_n   = n; cur_src = src; cur_upd = upd;
      cur_e   = (int'(e_hi) * 256 + (e % 256)) % (1 << AW);
      lat_min = lmin; lat_max = lmax; rdy_all = rdy1;
      cyc = 0; again_cyc = again; done_cyc = 0; wbdone_cyc = 0;
      n_init = 0; n_wb = 0; n_done = 0; init_wait = 0; wb_wait = 0;
      hs_cnt = 0; inflight = 0; max_inflight = 0;
      q_due.delete(); q_upd.delete(); log_idx.delete(); log_det.delete();
      start = 1'b1;
      step();
      chk({t, ":busy_after_start"}, busy, 1);
   endtask

   task automatic finish_case(input string t);
      int passes, pc, exp_idx;
      bit neg, det, exp_det;
      model(cur_n, cur_e, cur_upd, passes, pc, neg, det);
      while (n_done == 0 && cyc < 5000) step();
      chk({t, ":finished"}, n_done != 0, 1);
      step();
      chk({t, ":busy_end"}, busy, 0);
      chk({t, ":done_once"}, n_done, 1);
      chk({t, ":src_node"}, src_node, cur_src);
      chk({t, ":pass_count"}, pass_count, pc);
      chk({t, ":NegCycle"}, NegCycle, neg);
      chk({t, ":init_req_cnt"}, n_init, 1);
      chk({t, ":wb_req_cnt"}, n_wb, 1);
      chk({t, ":done_after_wb"}, done_cyc > wbdone_cyc, 1);
      chk({t, ":protocol_err"}, protocol_err, 0);
      chk({t, ":issued_total"}, log_idx.size(), passes * cur_e);
      chk({t, ":max_inflight_bound"}, max_inflight <= MAX_OUT, 1);
      if (rdy_all && lat_min > MAX_OUT && cur_e >= MAX_OUT)
         chk({t, ":max_inflight_reached"}, max_inflight, MAX_OUT);
      for (int k = 0; k < log_idx.size(); k++) begin
         exp_idx = (cur_e == 0) ? -1 : k % cur_e;
         exp_det = det && (cur_e != 0) && (k / cur_e == passes - 1);
         chk($sformatf("%s:idx[%0d]", t, k), log_idx[k], exp_idx);
         chk($sformatf("%s:det[%0d]", t, k), log_det[k], exp_det);
      end
   endtask

   task automatic run_case(input string t, input int n, input int src, input int e,
                           input logic [7:0] hi_junk, input int upd, input int lmin,
                           input int lmax, input bit rdy1, input int again);
      begin_case(t, n, src, e, hi_junk, upd, lmin, lmax, rdy1, again);
      finish_case(t);
   endtask

   initial begin
      int n, e;
      hdr[0] = 8'h00; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h00;
      cyc = 0; again_cyc = -1; lat_min = 1; lat_max = 1; rdy_all = 1'b0;
      cur_e = 0; cur_upd = 0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      reset = 1'b1;

      // Stray result while idle
      res_valid = 1'b1;
      step();
      chk("idle_stray:protocol_err", protocol_err, 1);
      chk("idle_stray:busy", busy, 0);

      // Convergence after pass 3 of 3, with a spurious start mid-run
      run_case("conv", 4, 0, 5, 8'h00, 2, 1, 4, 1'b0, 12);
      // Always improving: 2 relaxation passes then a detection pass
      run_case("negcyc", 3, 7, 3, 8'h00, 255, 1, 3, 1'b0, 30);
      // No edges: straight from INIT to writeback
      run_case("e_zero", 5, 2, 0, 8'h00, 255, 1, 2, 1'b0, -1);
      // Long fixed latency: in-flight limit throttles issue
      run_case("throttle", 4, 1, 7, 8'h00, 1, 10, 10, 1'b1, -1);
      // N<=1: detection pass immediately after init
      run_case("n_one_clean", 1, 3, 4, 8'h00, 0, 1, 3, 1'b0, -1);
      run_case("n_one_neg", 1, 3, 4, 8'h00, 5, 1, 3, 1'b0, -1);
      // E high bits above AW are dropped
      run_case("e_trunc", 3, 9, 3, 8'hE0, 0, 1, 2, 1'b0, -1);

      // Reset during pass 2 ISSUE, then a stale result after release
      begin_case("rst", 5, 6, 6, 8'h00, 255, 1, 3, 1'b0, -1);
      while (hs_cnt <= cur_e && cyc < 2000) step();
      chk("rst:reached_pass2", hs_cnt > cur_e, 1);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      step();
      check_reset_outputs("rst_held");
      reset = 1'b1;
      q_due.delete(); q_upd.delete(); inflight = 0;
      res_valid = 1'b1;
      step();
      chk("rst:stale_result_err", protocol_err, 1);
      run_case("after_rst", 4, 5, 4, 8'h00, 255, 1, 4, 1'b0, -1);

      // Random header, improvement profile, latency and ready pattern
      for (int i = 0; i < 6; i++) begin
         n = $urandom_range(6, 0);
         e = $urandom_range(9, 0);
         run_case($sformatf("rnd%0d", i), n, $urandom_range(255, 0), e, 8'h00,
                  $urandom_range(7, 0), 1, $urandom_range(6, 1), 1'($urandom_range(1, 0)),
                  $urandom_range(40, 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
